// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state type and the
// execute-stage sizing constants.
package div_unit_pkg;

    localparam int XLEN    = 32;
    localparam int BMASK_W = 4;
    localparam int ALU_num = 3;
    localparam int TAG_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        diff     = rem_sh - {1'b0, divisor};
        // diff[XLEN] is the borrow: set means the trial subtraction failed.
        quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
        rem_next = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider functional unit: one op in flight, tagged and
// branch-masked, result held until acknowledged or squashed.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN    = div_unit_pkg::XLEN,
    parameter int BMASK_W = div_unit_pkg::BMASK_W,
    parameter int CLR_N   = div_unit_pkg::ALU_num,
    parameter int TAG_W   = div_unit_pkg::TAG_W
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    output logic                               ready,
    input  logic                               sign,
    input  logic [XLEN-1:0]                    dividend,
    input  logic [XLEN-1:0]                    divisor,
    input  logic [TAG_W-1:0]                   tag_in,
    input  logic [BMASK_W-1:0]                 b_mask_in,
    input  logic                               clean_brat_en,
    input  logic [$clog2(BMASK_W)-1:0]         clean_brat_num,
    input  logic [CLR_N-1:0]                   clean_bit_brat_en,
    input  logic [CLR_N*$clog2(BMASK_W)-1:0]   clean_bit_brat_num,
    output logic                               done,
    input  logic                               result_ack,
    output logic [XLEN-1:0]                    quotient,
    output logic [XLEN-1:0]                    remainder,
    output logic [TAG_W-1:0]                   tag_out,
    output logic [BMASK_W-1:0]                 b_mask_out
);

    localparam int BIDX_W = $clog2(BMASK_W);
    localparam int CNT_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    div_state_e         state, next_state;
    logic [CNT_W-1:0]   count;
    logic [XLEN-1:0]    rem_q, quo_q, div_q;
    logic [XLEN-1:0]    rem_next, quo_next;
    logic [XLEN-1:0]    quotient_q, remainder_q;
    logic [TAG_W-1:0]   tag_q;
    logic [BMASK_W-1:0] b_mask_q;
    logic               neg_quo, neg_rem;

    logic [BMASK_W-1:0] clear_vec;
    logic               start_squash, held_squash, accept;
    logic               a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        clear_vec = '0;
        for (int j = 0; j < CLR_N; j++) begin
            if (clean_bit_brat_en[j]) begin
                clear_vec[clean_bit_brat_num[j*BIDX_W +: BIDX_W]] = 1'b1;
            end
        end
    end

    // Squash tests use the mask before this cycle's clears are applied.
    assign start_squash = clean_brat_en && b_mask_in[clean_brat_num];
    assign held_squash  = clean_brat_en && b_mask_q[clean_brat_num] && (state != IDLE);
    assign accept       = (state == IDLE) && start && !start_squash;

    assign a_neg = sign && dividend[XLEN-1];
    assign b_neg = sign && divisor[XLEN-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = BUSY;
            BUSY: begin
                if (held_squash)             next_state = IDLE;
                else if (count == LAST_STEP) next_state = DONE;
            end
            DONE: if (held_squash || result_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            tag_q       <= '0;
            b_mask_q    <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            rem_q    <= '0;
            quo_q    <= a_mag;
            div_q    <= b_mag;
            tag_q    <= tag_in;
            b_mask_q <= b_mask_in & ~clear_vec;
            // Divide-by-zero keeps the all-ones quotient unsigned.
            neg_quo  <= (a_neg ^ b_neg) && (divisor != '0);
            neg_rem  <= a_neg;
        end else if (held_squash) begin
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            tag_q       <= '0;
            b_mask_q    <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else begin
            b_mask_q <= b_mask_q & ~clear_vec;
            if (state == BUSY) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                count <= count + 1'b1;
                if (count == LAST_STEP) begin
                    quotient_q  <= neg_quo ? -quo_next : quo_next;
                    remainder_q <= neg_rem ? -rem_next : rem_next;
                end
            end
        end
    end

    assign ready      = (state == IDLE);
    assign done       = (state == DONE);
    assign quotient   = quotient_q;
    assign remainder  = remainder_q;
    assign tag_out    = tag_q;
    assign b_mask_out = b_mask_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written
// branch/reset sequences and random ops against an arithmetic reference.
module tb_div_unit;

    localparam int XLEN    = 32;
    localparam int BMASK_W = 4;
    localparam int CLR_N   = 3;
    localparam int TAG_W   = 6;
    localparam int BIDX_W  = 2;
    localparam int LAT     = XLEN + 1;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      start;
    logic                      ready;
    logic                      sign;
    logic [XLEN-1:0]           dividend, divisor;
    logic [TAG_W-1:0]          tag_in;
    logic [BMASK_W-1:0]        b_mask_in;
    logic                      clean_brat_en;
    logic [BIDX_W-1:0]         clean_brat_num;
    logic [CLR_N-1:0]          clean_bit_brat_en;
    logic [CLR_N*BIDX_W-1:0]   clean_bit_brat_num;
    logic                      done;
    logic                      result_ack;
    logic [XLEN-1:0]           quotient, remainder;
    logic [TAG_W-1:0]          tag_out;
    logic [BMASK_W-1:0]        b_mask_out;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .ready              (ready),
        .sign               (sign),
        .dividend           (dividend),
        .divisor            (divisor),
        .tag_in             (tag_in),
        .b_mask_in          (b_mask_in),
        .clean_brat_en      (clean_brat_en),
        .clean_brat_num     (clean_brat_num),
        .clean_bit_brat_en  (clean_bit_brat_en),
        .clean_bit_brat_num (clean_bit_brat_num),
        .done               (done),
        .result_ack         (result_ack),
        .quotient           (quotient),
        .remainder          (remainder),
        .tag_out            (tag_out),
        .b_mask_out         (b_mask_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // RISC-V division semantics written directly from the arithmetic rules.
    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive_start(input logic sg, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tg, input logic [BMASK_W-1:0] m);
        start     = 1'b1;
        sign      = sg;
        dividend  = a;
        divisor   = b;
        tag_in    = tg;
        b_mask_in = m;
    endtask

    // Waits for done with a cycle budget; n is the cycle index where done was seen.
    task automatic wait_done(input int n_in, output int n);
        n = n_in;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic [TAG_W-1:0] tg);
        int n;
        drive_start(sg, a, b, tg, 4'b0000);
        tick();
        start = 1'b0;
        wait_done(1, n);
        check({name, " latency"}, 64'(n), 64'(LAT));
        check({name, " quotient"}, 64'(quotient), 64'(eq));
        check({name, " remainder"}, 64'(remainder), 64'(er));
        check({name, " tag"}, 64'(tag_out), 64'(tg));
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check({name, " ready after ack"}, 64'(ready), 64'd1);
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        logic [31:0] rq, rr, ra, rb;
        logic rs;

        vecs[0] = '{"u 100/7",         1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{"s -7/2",          1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{"s 7/-2",          1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{"u 1234/0",        1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
        vecs[4] = '{"s 1234/0",        1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
        vecs[5] = '{"s overflow",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[6] = '{"u max/1",         1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{"s -7/0",          1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[8] = '{"u 80000000/max",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[9] = '{"s -100/-7",       1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};

        reset = 1'b1;
        start = 1'b0;
        sign = 1'b0;
        dividend = '0;
        divisor = '0;
        tag_in = '0;
        b_mask_in = '0;
        clean_brat_en = 1'b0;
        clean_brat_num = '0;
        clean_bit_brat_en = '0;
        clean_bit_brat_num = '0;
        result_ack = 1'b0;
        #12;
        check("reset ready", 64'(ready), 64'd1);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset tag_out", 64'(tag_out), 64'd0);
        check("reset b_mask_out", 64'(b_mask_out), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // 100/7 with held result and a start attempted in the ack cycle.
        drive_start(1'b0, 32'd100, 32'd7, 6'h2A, 4'b0000);
        tick();
        start = 1'b0;
        check("busy not ready", 64'(ready), 64'd0);
        wait_done(1, n);
        check("hold latency", 64'(n), 64'(LAT));
        for (int k = 0; k < 5; k++) begin
            check("hold done", 64'(done), 64'd1);
            check("hold quotient", 64'(quotient), 64'd14);
            check("hold remainder", 64'(remainder), 64'd2);
            check("hold tag", 64'(tag_out), 64'h2A);
            tick();
        end
        result_ack = 1'b1;
        start = 1'b1;
        tick();
        result_ack = 1'b0;
        start = 1'b0;
        check("ack ready", 64'(ready), 64'd1);
        check("ack done", 64'(done), 64'd0);
        tick();
        check("no start in ack cycle", 64'(ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r, 6'(i + 1));
        end

        // Mask-bit clear in cycle 5, then a squash on the cleared index in cycle 10.
        drive_start(1'b0, 32'd1000, 32'd9, 6'h11, 4'b0100);
        tick();
        start = 1'b0;
        repeat (4) tick();
        clean_bit_brat_en = 3'b010;
        clean_bit_brat_num = 6'b00_10_00;
        tick();
        clean_bit_brat_en = '0;
        clean_bit_brat_num = '0;
        check("mask cleared", 64'(b_mask_out), 64'd0);
        repeat (4) tick();
        clean_brat_en = 1'b1;
        clean_brat_num = 2'd2;
        tick();
        clean_brat_en = 1'b0;
        check("cleared bit no squash", 64'(ready), 64'd0);
        wait_done(11, n);
        check("cleared latency", 64'(n), 64'(LAT));
        check("cleared quotient", 64'(quotient), 64'd111);
        check("cleared remainder", 64'(remainder), 64'd1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;

        // Squash in cycle 12, then a fresh op starting in cycle 13.
        drive_start(1'b0, 32'd50, 32'd5, 6'h05, 4'b0010);
        tick();
        start = 1'b0;
        repeat (11) tick();
        clean_brat_en = 1'b1;
        clean_brat_num = 2'd1;
        tick();
        clean_brat_en = 1'b0;
        check("squash ready", 64'(ready), 64'd1);
        check("squash done", 64'(done), 64'd0);
        check("squash mask", 64'(b_mask_out), 64'd0);
        run_op("after squash", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 6'h06);

        // Squash beats ack in DONE, despite a same-cycle clear of that bit.
        drive_start(1'b0, 32'd9, 32'd2, 6'h07, 4'b0001);
        tick();
        start = 1'b0;
        wait_done(1, n);
        check("pre-squash done", 64'(done), 64'd1);
        result_ack = 1'b1;
        clean_brat_en = 1'b1;
        clean_brat_num = 2'd0;
        clean_bit_brat_en = 3'b001;
        clean_bit_brat_num = '0;
        tick();
        result_ack = 1'b0;
        clean_brat_en = 1'b0;
        clean_bit_brat_en = '0;
        check("squash over ack ready", 64'(ready), 64'd1);
        check("squash zeroes quotient", 64'(quotient), 64'd0);
        check("squash zeroes tag", 64'(tag_out), 64'd0);

        // Asynchronous reset mid-op.
        drive_start(1'b0, 32'd500, 32'd3, 6'h09, 4'b0000);
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async reset ready", 64'(ready), 64'd1);
        check("async reset done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Start in the same cycle as a squash of one of its own mask bits.
        drive_start(1'b0, 32'd40, 32'd4, 6'h0A, 4'b0100);
        clean_brat_en = 1'b1;
        clean_brat_num = 2'd2;
        tick();
        start = 1'b0;
        clean_brat_en = 1'b0;
        check("start squashed ready", 64'(ready), 64'd1);
        tick();
        check("start squashed done", 64'(done), 64'd0);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = $urandom;
                2: rb = 32'($urandom_range(0, 1)) ? 32'hFFFF_FFFF : 32'd0;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(rs, ra, rb, rq, rr);
            run_op("random", rs, ra, rb, rq, rr, 6'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
